replica_sink: RTL

// - Receiving end of the replica shift chain: captures the tour words shifted out of the last

---
 rtl/replica_sink.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/replica_sink.sv
// replica_sink: receiving end of the replica shift chain; buffers every tour and pulses done.
// Define REPLICA_SINK_PERM_CHECK_EN to enable the per-tour city permutation check (err_perm).
module replica_sink #(
  parameter int REPLICA_NUM = 4,
  parameter int LANES       = 8,
  parameter int CITY_W      = 7,
  parameter int CITY_DIV    = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      in_valid,
  input  logic [LANES*CITY_W-1:0]                   in_data,
  output logic                                      busy,
  output logic                                      done,
  output logic [REPLICA_NUM-1:0]                    err_perm,
  output logic                                      err_overrun,
  input  logic                                      rd_en,
  input  logic [$clog2(REPLICA_NUM*CITY_DIV)-1:0]   rd_addr,
  output logic [LANES*CITY_W-1:0]                   rd_data
);

  localparam int CITY_NUM = LANES * CITY_DIV;
  localparam int DEPTH    = REPLICA_NUM * CITY_DIV;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int DATA_W   = LANES * CITY_W;
  localparam int REP_W    = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1;
  localparam int BEAT_W   = (CITY_DIV > 1) ? $clog2(CITY_DIV) : 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t              state;
  logic [REP_W-1:0]    rep_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_en;
  logic                last_beat_of_tour;
  logic                last_rep;
  logic                rd_in_range;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign wr_addr           = ADDR_W'(rep_cnt) * ADDR_W'(CITY_DIV) + ADDR_W'(beat_cnt);
  assign last_beat_of_tour = (beat_cnt == BEAT_W'(CITY_DIV - 1));
  assign last_rep          = (rep_cnt == REP_W'(REPLICA_NUM - 1));
  // A start or reset in the same cycle discards the beat, so it must not reach the buffer.
  assign wr_en             = (state == RECV) && in_valid && !start && !reset;

`ifdef REPLICA_SINK_PERM_CHECK_EN
  localparam int IDX_W = $clog2(CITY_NUM);

  logic [CITY_NUM-1:0] seen;
  logic [CITY_NUM-1:0] seen_next;
  logic                perm_hit;
  logic [CITY_W-1:0]   city;

  // Lanes are folded in order so a duplicate inside one beat is caught as well.
  always_comb begin
    seen_next = seen;
    perm_hit  = 1'b0;
    city      = '0;
    for (int i = 0; i < LANES; i++) begin
      city = in_data[i*CITY_W +: CITY_W];
      if (city >= CITY_W'(CITY_NUM)) begin
        perm_hit = 1'b1;
      end else if (seen_next[city[IDX_W-1:0]]) begin
        perm_hit = 1'b1;
      end else begin
        seen_next[city[IDX_W-1:0]] = 1'b1;
      end
    end
  end
`else
  assign err_perm = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
      rep_cnt     <= '0;
      beat_cnt    <= '0;
`ifdef REPLICA_SINK_PERM_CHECK_EN
      err_perm    <= '0;
      seen        <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= RECV;
        busy        <= 1'b1;
        err_overrun <= 1'b0;
        rep_cnt     <= '0;
        beat_cnt    <= '0;
`ifdef REPLICA_SINK_PERM_CHECK_EN
        err_perm    <= '0;
        seen        <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              err_overrun <= 1'b1;
            end
          end
          RECV: begin
            if (in_valid) begin
`ifdef REPLICA_SINK_PERM_CHECK_EN
              if (perm_hit) begin
                err_perm[rep_cnt] <= 1'b1;
              end
              seen <= last_beat_of_tour ? '0 : seen_next;
`endif
              if (last_beat_of_tour) begin
                beat_cnt <= '0;
                if (last_rep) begin
                  rep_cnt <= '0;
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                end else begin
                  rep_cnt <= rep_cnt + REP_W'(1);
                end
              end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Buffer contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
  end

  if (DEPTH == (1 << ADDR_W)) begin : g_full_range
    assign rd_in_range = 1'b1;
  end else begin : g_part_range
    assign rd_in_range = (rd_addr < ADDR_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

endmodule
